mem_access_ctrl: RTL and testbench

Parametrised memory-stage access controller for the pipelined LC-3b core. It sits between the EX/MEM pipeline register and the data-memory bus. It sequences single-access (LDR/LDB/STR/STB/TRAP) and two-access indirect (LDI/STI) operations through an explicit state machine, and holds the pipeline with `stall` until the final acknowledge. It adds byte-lane steering, load-byte extraction and a bus timeout.

---
 rtl/mem_access_ctrl_pkg.sv | 47 ++++
 rtl/mem_access_ctrl_lane_steer.sv | 34 +++
 rtl/mem_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lc3b_types (package)
// Brief   : LC-3b opcode and memory-stage state types with opcode classifiers.
// Revision: 1.0
// ============================================================================
package lc3b_types;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0, OP_ADD  = 4'h1, OP_LDB  = 4'h2, OP_STB  = 4'h3,
        OP_JSR  = 4'h4, OP_AND  = 4'h5, OP_LDR  = 4'h6, OP_STR  = 4'h7,
        OP_RTI  = 4'h8, OP_NOT  = 4'h9, OP_LDI  = 4'hA, OP_STI  = 4'hB,
        OP_JMP  = 4'hC, OP_SHF  = 4'hD, OP_LEA  = 4'hE, OP_TRAP = 4'hF
    } lc3b_opcode;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2
    } lc3b_mem_state_t;

    function automatic logic is_mem_op(input lc3b_opcode op);
        return (op == OP_LDR) || (op == OP_LDB) || (op == OP_STR) ||
               (op == OP_STB) || (op == OP_LDI) || (op == OP_STI) ||
               (op == OP_TRAP);
    endfunction

    function automatic logic is_indirect(input lc3b_opcode op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_load(input lc3b_opcode op);
        return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI) ||
               (op == OP_TRAP);
    endfunction

    function automatic logic is_byte_op(input lc3b_opcode op);
        return (op == OP_LDB) || (op == OP_STB);
    endfunction

    // Only the direct stores write on the first access; STI writes on the second.
    function automatic logic is_direct_store(input lc3b_opcode op);
        return (op == OP_STR) || (op == OP_STB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_lane_steer.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_steer
// Brief   : Byte-lane select, store-byte replication and load-byte extraction.
// Revision: 1.0
// ============================================================================
module mem_lane_steer #(
    parameter  int DATA_W = 16,
    localparam int BE_W   = DATA_W / 8,
    localparam int LANE_W = (BE_W > 1) ? $clog2(BE_W) : 1
) (
    input  logic [LANE_W-1:0] lane,
    input  logic              byte_en,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] rdata_in,
    output logic [BE_W-1:0]   sel,
    output logic [DATA_W-1:0] wdata_out,
    output logic [DATA_W-1:0] rdata_out
);

    logic [7:0] w_bytes [BE_W];

    generate
        for (genvar i = 0; i < BE_W; i++) begin : g_lane
            assign w_bytes[i] = rdata_in[i*8 +: 8];
        end
    endgenerate

    assign sel       = byte_en ? (BE_W'(1) << lane) : '1;
    assign wdata_out = byte_en ? {BE_W{wdata_in[7:0]}} : wdata_in;
    assign rdata_out = {{(DATA_W-8){1'b0}}, w_bytes[lane]};

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : LC-3b memory-stage bus sequencer for direct and indirect accesses.
// Revision: 1.0
// ============================================================================
module mem_access_ctrl
    import lc3b_types::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int BE_W    = DATA_W / 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  lc3b_opcode        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_cyc,
    output logic              mem_stb,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_sel,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err
);

    localparam int c_LANE_W = (BE_W > 1) ? $clog2(BE_W) : 1;
    localparam int c_CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lc3b_mem_state_t     r_state, w_state_nxt;
    lc3b_opcode          r_op;
    logic [c_LANE_W-1:0] r_lane;
    logic [c_CNT_W-1:0]  r_wait;

    logic                w_start;
    logic                w_timeout;
    logic [c_LANE_W-1:0] w_lane;
    logic                w_byte;
    logic [BE_W-1:0]     w_sel;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rbyte;

    assign w_start = start && is_mem_op(opcode) && (r_state == IDLE);

    // Counter holds TIMEOUT-1 during the last strobe cycle that may still be acked.
    assign w_timeout = (TIMEOUT != 0) && (r_state != IDLE) && !mem_ack &&
                       (r_wait == c_CNT_W'(TIMEOUT - 1));

    // Request-side steering uses the live inputs; response-side uses the latched lane.
    assign w_lane = (r_state == IDLE) ? addr[c_LANE_W-1:0] : r_lane;
    assign w_byte = (r_state == IDLE) ? is_byte_op(opcode) : is_byte_op(r_op);

    mem_lane_steer #(
        .DATA_W (DATA_W)
    ) u_steer (
        .lane      (w_lane),
        .byte_en   (w_byte),
        .wdata_in  (wdata_in),
        .rdata_in  (mem_rdata),
        .sel       (w_sel),
        .wdata_out (w_wdata),
        .rdata_out (w_rbyte)
    );

    assign mem_stb = mem_cyc;

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = ACC1;
                    stall       = 1'b1;
                end
            end
            ACC1: begin
                stall = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = is_indirect(r_op) ? ACC2 : IDLE;
                    stall       = is_indirect(r_op);
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                    stall       = 1'b0;
                end
            end
            ACC2: begin
                stall = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_state_nxt = IDLE;
                    stall       = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_BR;
            r_lane      <= '0;
            r_wait      <= '0;
            mem_cyc     <= 1'b0;
            mem_we      <= 1'b0;
            mem_sel     <= '0;
            mem_adr     <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            rdata_valid <= 1'b0;
            err         <= w_timeout;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_op      <= opcode;
                        r_lane    <= addr[c_LANE_W-1:0];
                        r_wait    <= '0;
                        mem_cyc   <= 1'b1;
                        mem_we    <= is_direct_store(opcode);
                        mem_sel   <= w_sel;
                        mem_adr   <= addr;
                        mem_wdata <= w_wdata;
                    end
                end
                ACC1, ACC2: begin
                    if (mem_ack) begin
                        r_wait <= '0;
                        if ((r_state == ACC1) && is_indirect(r_op)) begin
                            // Pointer fetched; bus cycle stays open for the second access.
                            mem_adr <= ADDR_W'(mem_rdata);
                            mem_we  <= (r_op == OP_STI);
                        end else begin
                            mem_cyc <= 1'b0;
                            mem_we  <= 1'b0;
                            if (is_load(r_op)) begin
                                rdata       <= is_byte_op(r_op) ? w_rbyte : mem_rdata;
                                rdata_valid <= 1'b1;
                            end
                        end
                    end else if (w_timeout) begin
                        mem_cyc <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        r_wait <= r_wait + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Vector table plus hand sequences for timeout and mid-access reset.
// Revision: 1.0
// ============================================================================
module tb_mem_access_ctrl;
    import lc3b_types::*;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int BE_W    = 2;
    localparam int TIMEOUT = 8;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    lc3b_opcode        opcode    = OP_BR;
    logic [ADDR_W-1:0] addr      = '0;
    logic [DATA_W-1:0] wdata_in  = '0;
    logic              mem_ack   = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_cyc, mem_stb, mem_we, stall, rdata_valid, err;
    logic [BE_W-1:0]   mem_sel;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata, rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .opcode      (opcode),
        .addr        (addr),
        .wdata_in    (wdata_in),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_cyc     (mem_cyc),
        .mem_stb     (mem_stb),
        .mem_we      (mem_we),
        .mem_sel     (mem_sel),
        .mem_adr     (mem_adr),
        .mem_wdata   (mem_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err)
    );

    typedef struct {
        lc3b_opcode  op;
        logic [15:0] adr;
        logic [15:0] wd;
        int          n_acc;
        int          d1;
        logic [15:0] r1;
        int          d2;
        logic [15:0] r2;
        logic        we1;
        logic [1:0]  sel1;
        logic [15:0] ewd1;
        logic [15:0] ewd2;
        logic [15:0] erd;
        logic        eval;
    } vec_t;

    typedef struct {
        logic [15:0] adr;
        logic        we;
        logic [1:0]  sel;
        logic [15:0] wd;
        logic        chk_wd;
    } acc_t;

    acc_t        q_acc [$];
    logic [15:0] q_rd  [$];
    vec_t        vecs  [11];
    logic [15:0] last_rd = 16'h0000;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          n_err   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: acked bus accesses and rdata_valid pulses pop expected records.
    always @(negedge clk) begin
        acc_t        e;
        logic [15:0] er;
        #2;
        if (rst_n && mem_cyc && mem_stb && mem_ack) begin
            if (q_acc.size() == 0) begin
                check("unexpected_access", 32'd1, 32'd0);
            end else begin
                e = q_acc.pop_front();
                check("acc_adr", mem_adr, e.adr);
                check("acc_we",  mem_we,  e.we);
                check("acc_sel", mem_sel, e.sel);
                if (e.chk_wd) check("acc_wdata", mem_wdata, e.wd);
            end
        end
        if (rdata_valid) begin
            if (q_rd.size() == 0) begin
                check("unexpected_rdata_valid", 32'd1, 32'd0);
            end else begin
                er = q_rd.pop_front();
                check("rdata", rdata, er);
            end
        end
        if (err) n_err++;
        if (start && mem_cyc) check("start_while_busy", 32'd1, 32'd0);
    end

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        start    = 1'b1;
        opcode   = v.op;
        addr     = v.adr;
        wdata_in = v.wd;
        if (v.n_acc > 0) begin
            q_acc.push_back('{v.adr, v.we1, v.sel1, v.ewd1, v.we1});
            if (v.n_acc == 2)
                q_acc.push_back('{v.r1, v.op == OP_STI, 2'b11, v.ewd2, v.op == OP_STI});
            if (v.eval) begin
                q_rd.push_back(v.erd);
                last_rd = v.erd;
            end
        end
        #1 check($sformatf("v%0d_stall_start", idx), stall, v.n_acc > 0);
        @(negedge clk);
        start  = 1'b0;
        opcode = OP_BR;
        if (v.n_acc == 0) begin
            #1;
            check($sformatf("v%0d_nomem_cyc", idx), mem_cyc, 1'b0);
            check($sformatf("v%0d_nomem_stall", idx), stall, 1'b0);
            return;
        end
        for (int a = 1; a <= v.n_acc; a++) begin
            int d;
            d = (a == 1) ? v.d1 : v.d2;
            for (int i = 0; i < d; i++) begin
                #1;
                check($sformatf("v%0d_a%0d_wait_cyc", idx, a), mem_cyc, 1'b1);
                check($sformatf("v%0d_a%0d_wait_stall", idx, a), stall, 1'b1);
                @(negedge clk);
            end
            #1;
            check($sformatf("v%0d_a%0d_cyc", idx, a), {mem_cyc, mem_stb}, 2'b11);
            check($sformatf("v%0d_a%0d_stall_pre", idx, a), stall, 1'b1);
            mem_ack   = 1'b1;
            mem_rdata = (a == 1) ? v.r1 : v.r2;
            #1 check($sformatf("v%0d_a%0d_stall_ack", idx, a), stall, a < v.n_acc);
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
        end
        #1;
        check($sformatf("v%0d_done_cyc", idx), mem_cyc, 1'b0);
        check($sformatf("v%0d_done_stall", idx), stall, 1'b0);
        check($sformatf("v%0d_done_err", idx), err, 1'b0);
        check($sformatf("v%0d_done_valid", idx), rdata_valid, v.eval);
        check($sformatf("v%0d_done_rdata", idx), rdata, last_rd);
    endtask

    initial begin
        int cnt;
        //         op       adr       wd        n d1 r1        d2 r2        we sel    ewd1      ewd2      erd       val
        vecs[0]  = '{OP_LDR,  16'h3000, 16'h0000, 1, 0, 16'hBEEF, 0, 16'h0000, 0, 2'b11, 16'h0000, 16'h0000, 16'hBEEF, 1};
        vecs[1]  = '{OP_STB,  16'h3001, 16'h12AB, 1, 3, 16'h0000, 0, 16'h0000, 1, 2'b10, 16'hABAB, 16'h0000, 16'h0000, 0};
        vecs[2]  = '{OP_LDB,  16'h3000, 16'h0000, 1, 1, 16'h5A7C, 0, 16'h0000, 0, 2'b01, 16'h0000, 16'h0000, 16'h007C, 1};
        vecs[3]  = '{OP_LDB,  16'h3001, 16'h0000, 1, 0, 16'h5A7C, 0, 16'h0000, 0, 2'b10, 16'h0000, 16'h0000, 16'h005A, 1};
        vecs[4]  = '{OP_STI,  16'h4000, 16'h1234, 2, 0, 16'h5000, 0, 16'h0000, 0, 2'b11, 16'h0000, 16'h1234, 16'h0000, 0};
        vecs[5]  = '{OP_STR,  16'h2002, 16'hCAFE, 1, 2, 16'h0000, 0, 16'h0000, 1, 2'b11, 16'hCAFE, 16'h0000, 16'h0000, 0};
        vecs[6]  = '{OP_STB,  16'h3000, 16'h0077, 1, 0, 16'h0000, 0, 16'h0000, 1, 2'b01, 16'h7777, 16'h0000, 16'h0000, 0};
        vecs[7]  = '{OP_LDI,  16'h4100, 16'h0000, 2, 1, 16'h6000, 2, 16'h9876, 0, 2'b11, 16'h0000, 16'h0000, 16'h9876, 1};
        vecs[8]  = '{OP_TRAP, 16'h0025, 16'h0000, 1, 0, 16'h0400, 0, 16'h0000, 0, 2'b11, 16'h0000, 16'h0000, 16'h0400, 1};
        vecs[9]  = '{OP_ADD,  16'h3000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0};
        vecs[10] = '{OP_LDR,  16'h3000, 16'h0000, 1, 1, 16'h1357, 0, 16'h0000, 0, 2'b11, 16'h0000, 16'h0000, 16'h1357, 1};

        #1;
        check("reset_ctrl", {mem_cyc, mem_stb, mem_we, stall, rdata_valid, err}, 6'b0);
        check("reset_bus", {mem_sel, mem_adr, mem_wdata}, 34'h0);
        check("reset_rdata", rdata, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Timeout: LDR that is never acknowledged.
        @(negedge clk);
        start  = 1'b1;
        opcode = OP_LDR;
        addr   = 16'h3100;
        @(negedge clk);
        start  = 1'b0;
        opcode = OP_BR;
        cnt    = 0;
        while (mem_cyc && cnt < 20) begin
            #1 check($sformatf("to_stall_%0d", cnt), stall, cnt != TIMEOUT - 1);
            cnt++;
            @(negedge clk);
        end
        #1;
        check("to_strobe_cycles", cnt, TIMEOUT);
        check("to_err_pulse", err, 1'b1);
        check("to_stall_after", stall, 1'b0);
        check("to_rdata_held", rdata, last_rd);
        check("to_no_valid", rdata_valid, 1'b0);
        @(negedge clk);
        #1 check("to_err_single", err, 1'b0);

        // Reset during the ACC2 wait of an LDI.
        @(negedge clk);
        start  = 1'b1;
        opcode = OP_LDI;
        addr   = 16'h4200;
        q_acc.push_back('{16'h4200, 1'b0, 2'b11, 16'h0000, 1'b0});
        @(negedge clk);
        start     = 1'b0;
        opcode    = OP_BR;
        mem_ack   = 1'b1;
        mem_rdata = 16'h5100;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        #1;
        check("rst_seq_acc2_cyc", mem_cyc, 1'b1);
        check("rst_seq_acc2_adr", mem_adr, 16'h5100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {mem_cyc, mem_stb, mem_we, stall, rdata_valid, err}, 6'b0);
        check("rst_mid_bus", {mem_sel, mem_adr, mem_wdata}, 34'h0);
        check("rst_mid_rdata", rdata, 16'h0000);
        last_rd = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("rst_post_idle", {mem_cyc, rdata_valid, err}, 3'b0);

        run_vec(vecs[10], 10);

        repeat (2) @(negedge clk);
        check("sb_acc_drained", q_acc.size(), 0);
        check("sb_rd_drained", q_rd.size(), 0);
        check("err_pulse_count", n_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
